// File: rtl/serv_rf_dbg_access.sv
// Debug-side initiator for the SERV register-file RAM interface.
// Turns one parallel abstract command (read or write a GPR/CSR slot) into
// a bit-serial rreq/wreq transaction, shifting data one bit per cycle, and
// returns a parallel response.
//
// Handshakes: a command transfers on a clock edge where i_cmd_valid and
// o_cmd_ready are both high; a response transfers on an edge where
// o_rsp_valid and i_rsp_ready are both high. o_rsp_valid, o_rsp_rdata and
// o_rsp_err stay stable from assertion until that transfer.
module serv_rf_dbg_access #(
  parameter int csr_regs = 4,
  parameter int RW = $clog2(32 + csr_regs)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_halted,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_write,
  input  logic [RW-1:0] i_cmd_regno,
  input  logic [31:0]   i_cmd_wdata,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [31:0]   o_rsp_rdata,
  output logic          o_rsp_err,
  output logic          o_rreq,
  output logic          o_wreq,
  input  logic          i_ready,
  output logic [RW-1:0] o_rreg0,
  output logic [RW-1:0] o_rreg1,
  output logic [RW-1:0] o_wreg0,
  output logic [RW-1:0] o_wreg1,
  output logic          o_wen0,
  output logic          o_wen1,
  output logic          o_wdata0,
  output logic          o_wdata1,
  input  logic          i_rdata0,
  input  logic          i_rdata1,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RREQ   = 3'd1,
    RWAIT  = 3'd2,
    RSHIFT = 3'd3,
    WREQ   = 3'd4,
    WSHIFT = 3'd5,
    WDRAIN = 3'd6,
    RESP   = 3'd7
  } state_t;

  localparam logic [RW:0] num_slots = (RW+1)'(32 + csr_regs);

  state_t        state;
  logic [31:0]   sr;
  logic [RW-1:0] idx;
  logic [4:0]    cnt;
  logic          in_txn;
  logic          bad_cmd;
  logic          unused;

  // Port 1 of the RF interface is never used for debug access.
  assign o_wen1   = 1'b0;
  assign o_wdata1 = 1'b0;
  assign unused   = i_rdata1;

  // Register indices are only presented while the RF is actually being accessed.
  assign in_txn  = (state != IDLE) && (state != RESP);
  assign o_rreg0 = in_txn ? idx : '0;
  assign o_rreg1 = in_txn ? idx : '0;
  assign o_wreg0 = in_txn ? idx : '0;
  assign o_wreg1 = in_txn ? idx : '0;

  assign dbg_state = state;

  // Out-of-range slot or running core: reject without touching the RF.
  assign bad_cmd = ({1'b0, i_cmd_regno} >= num_slots) || !i_halted;

  // Transaction sequencer with registered strobes, shift register and response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      sr          <= '0;
      idx         <= '0;
      cnt         <= '0;
      o_cmd_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      o_rreq      <= 1'b0;
      o_wreq      <= 1'b0;
      o_wen0      <= 1'b0;
      o_wdata0    <= 1'b0;
    end else begin
      // Request strobes are single-cycle pulses unless re-armed below.
      o_rreq <= 1'b0;
      o_wreq <= 1'b0;
      case (state)
        IDLE: begin
          o_cmd_ready <= 1'b1;
          if (o_cmd_ready && i_cmd_valid) begin
            o_cmd_ready <= 1'b0;
            sr          <= i_cmd_wdata;
            idx         <= i_cmd_regno;
            if (bad_cmd) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= '0;
            end else if (i_cmd_regno == '0) begin
              // x0 is hardwired: reads return zero, writes are dropped.
              state       <= RESP;
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b0;
              o_rsp_rdata <= '0;
            end else if (i_cmd_write) begin
              state  <= WREQ;
              o_wreq <= 1'b1;
              o_wen0 <= 1'b1;
            end else begin
              state  <= RREQ;
              o_rreq <= 1'b1;
            end
          end
        end
        RREQ: begin
          state <= RWAIT;
        end
        RWAIT: begin
          if (i_ready) begin
            state <= RSHIFT;
            cnt   <= '0;
          end
        end
        RSHIFT: begin
          sr  <= {i_rdata0, sr[31:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= {i_rdata0, sr[31:1]};
          end
        end
        WREQ: begin
          // The interface is ready during wreq, so bit 0 goes out next cycle.
          o_wdata0 <= sr[0];
          sr       <= {1'b0, sr[31:1]};
          cnt      <= '0;
          state    <= WSHIFT;
        end
        WSHIFT: begin
          if (cnt == 5'd31) begin
            o_wen0   <= 1'b0;
            o_wdata0 <= 1'b0;
            cnt      <= '0;
            state    <= WDRAIN;
          end else begin
            o_wdata0 <= sr[0];
            sr       <= {1'b0, sr[31:1]};
            cnt      <= cnt + 5'd1;
          end
        end
        WDRAIN: begin
          // Two idle cycles let the interface flush its final word.
          if (cnt == 5'd1) begin
            cnt         <= '0;
            state       <= RESP;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_cmd_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serv_rf_dbg_access.sv
// Testbench for serv_rf_dbg_access: behavioural RF interface + RAM model,
// directed command sequence, response scoreboard and summary.
module tb_serv_rf_dbg_access;

  localparam int RW = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic          halted, cmd_valid, cmd_ready, cmd_write;
  logic [RW-1:0] cmd_regno;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          rreq, wreq, rf_ready;
  logic [RW-1:0] rreg0, rreg1, wreg0, wreg1;
  logic          wen0, wen1, wdata0, wdata1, rdata0, rdata1;
  logic [2:0]    dbg_state;

  serv_rf_dbg_access #(.csr_regs(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_halted(halted),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_regno(cmd_regno), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_rreq(rreq), .o_wreq(wreq), .i_ready(rf_ready),
    .o_rreg0(rreg0), .o_rreg1(rreg1), .o_wreg0(wreg0), .o_wreg1(wreg1),
    .o_wen0(wen0), .o_wen1(wen1), .o_wdata0(wdata0), .o_wdata1(wdata1),
    .i_rdata0(rdata0), .i_rdata1(rdata1),
    .dbg_state(dbg_state)
  );

  // ---------------- RF interface + RAM model ----------------
  logic [31:0] mem [0:35];
  int  rd_cnt = 0;
  bit  rd_active = 1'b0;
  int  rd_idx = 0;
  int  rd_extra = 0;

  // Read side: ready two cycles after rreq (plus rd_extra), then LSB-first data.
  always @(negedge clk) begin
    rdata1 = 1'($urandom_range(0, 1));
    if (rst) begin
      rd_active = 1'b0;
      rf_ready  = 1'b0;
      rdata0    = 1'b0;
    end else begin
      if (rreq) begin
        rd_active = 1'b1;
        rd_cnt    = 0;
        rd_idx    = int'(rreg0);
      end else if (rd_active) begin
        rd_cnt++;
      end
      rf_ready = rd_active && (rd_cnt == 2 + rd_extra);
      rdata0   = 1'b0;
      if (rd_active && rd_cnt >= 3 + rd_extra && rd_cnt < 35 + rd_extra && rd_idx < 36)
        rdata0 = mem[rd_idx][rd_cnt - 3 - rd_extra];
      if (rd_active && rd_cnt >= 35 + rd_extra) rd_active = 1'b0;
    end
  end

  // Write side capture and bus monitors.
  int rreq_cnt, wreq_cnt, wen_cnt, rreq_cyc, wreq_cyc, wbit, wtime_bad, rsp_seen;
  int idx_bad = 0, side_bad = 0;
  logic [RW-1:0] exp_idx = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rreq) begin rreq_cnt++; rreq_cyc = cyc; end
      if (wreq) begin wreq_cnt++; wreq_cyc = cyc; wbit = 0; end
      if (wen0) wen_cnt++;
      if (wen0 && !wreq) begin
        if (wbit < 32 && int'(wreg0) < 36) mem[wreg0][wbit] = wdata0;
        if (wbit >= 32 || cyc != wreq_cyc + 1 + wbit) wtime_bad++;
        wbit++;
      end
      if (wen1 || wdata1) side_bad++;
      if (dbg_state != 3'd0 && dbg_state != 3'd7) begin
        if (rreg0 != exp_idx || rreg1 != exp_idx || wreg0 != exp_idx || wreg1 != exp_idx) idx_bad++;
      end else if (rreg0 != '0 || rreg1 != '0 || wreg0 != '0 || wreg1 != '0) begin
        idx_bad++;
      end
      if (rsp_valid) rsp_seen++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [40:0] exp_q[$];   // {err, latency[7:0], rdata}
  int checks = 0;
  int failures = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rreq_cnt = 0; wreq_cnt = 0; wen_cnt = 0; wtime_bad = 0;
    wbit = 0; rsp_seen = 0; rreq_cyc = -1; wreq_cyc = -1;
  endtask

  // ---------------- drivers ----------------
  task automatic send_cmd(input logic wr, input logic [RW-1:0] regno, input logic [31:0] wd);
    bit found = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_regno = regno; cmd_wdata = wd;
    exp_idx = regno;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        found = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("cmd_accept", 64'(found), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for a response, compare it with the queue head, optionally hold it
  // (with a competing command pending) before consuming it.
  task automatic wait_rsp(input string tag, input int hold);
    bit got = 1'b0;
    int rcyc = 0;
    logic [40:0] e;
    for (int i = 0; i < 120; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        rcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    chk({tag, "_rsp_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, "_lat"}, 64'(rcyc - acc_cyc), 64'(e[39:32]));
      chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e[31:0]));
      chk({tag, "_err"}, 64'(rsp_err), 64'(e[40]));
    end
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_regno = 6'd5; exp_idx = 6'd5;
      @(negedge clk);
      chk({tag, "_hold"}, {rsp_valid, cmd_ready, rsp_err, rsp_rdata},
          {1'b1, 1'b0, e[40], e[31:0]});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_txn(input string tag, input logic wr, input logic [RW-1:0] regno,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat);
    clear_mon();
    exp_q.push_back({exp_err, 8'(exp_lat), exp_rd});
    send_cmd(wr, regno, wd);
    wait_rsp(tag, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    halted = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_regno = '0;
    cmd_wdata = '0; rsp_ready = 1'b0; rf_ready = 1'b0; rdata0 = 1'b0; rdata1 = 1'b0;
    for (int i = 0; i < 36; i++) mem[i] = 32'h1000_0000 + i;
    mem[32] = 32'h4000_0100;
    clear_mon();

    repeat (3) @(negedge clk);
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_err, rreq, wreq, wen0, wdata0}, 64'd0);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(cmd_ready), 64'd1);
    halted = 1'b1;

    // Write then read back x5.
    do_txn("wr_x5", 1'b1, 6'd5, 32'hDEAD_BEEF, 32'h0, 1'b0, 36);
    chk("wr_x5_wreq_cyc", 64'(wreq_cyc - acc_cyc), 64'd1);
    chk("wr_x5_wreq_cnt", 64'(wreq_cnt), 64'd1);
    chk("wr_x5_wen_cycles", 64'(wen_cnt), 64'd33);
    chk("wr_x5_bit_timing", 64'(wtime_bad), 64'd0);
    chk("wr_x5_no_rreq", 64'(rreq_cnt), 64'd0);
    chk("wr_x5_ram", 64'(mem[5]), 64'hDEAD_BEEF);

    do_txn("rd_x5", 1'b0, 6'd5, 32'h0, 32'hDEAD_BEEF, 1'b0, 36);
    chk("rd_x5_rreq_cyc", 64'(rreq_cyc - acc_cyc), 64'd1);
    chk("rd_x5_rreq_cnt", 64'(rreq_cnt), 64'd1);
    chk("rd_x5_no_wen", 64'(wen_cnt), 64'd0);

    // CSR slot 32.
    do_txn("rd_csr32", 1'b0, 6'd32, 32'h0, 32'h4000_0100, 1'b0, 36);

    // Out-of-range slot and not-halted write: immediate error, no RF access.
    do_txn("rd_36", 1'b0, 6'd36, 32'h0, 32'h0, 1'b1, 1);
    chk("rd_36_no_req", 64'(rreq_cnt + wreq_cnt), 64'd0);
    halted = 1'b0;
    do_txn("wr_x3_running", 1'b1, 6'd3, 32'h1234_5678, 32'h0, 1'b1, 1);
    chk("wr_x3_no_req", 64'(rreq_cnt + wreq_cnt + wen_cnt), 64'd0);
    halted = 1'b1;

    // x0 accesses never reach the RF.
    do_txn("wr_x0", 1'b1, 6'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
    chk("wr_x0_no_wen", 64'(wen_cnt + wreq_cnt), 64'd0);
    do_txn("rd_x0", 1'b0, 6'd0, 32'h0, 32'h0, 1'b0, 1);
    chk("rd_x0_no_rreq", 64'(rreq_cnt), 64'd0);

    // Late RF ready stretches the read.
    rd_extra = 3;
    do_txn("rd_x5_slow", 1'b0, 6'd5, 32'h0, 32'hDEAD_BEEF, 1'b0, 39);
    rd_extra = 0;

    // Response held for 5 cycles while a new command waits, then consumed
    // in the same cycle the command is still offered.
    clear_mon();
    exp_q.push_back({1'b0, 8'd36, 32'h1000_0007});
    send_cmd(1'b0, 6'd7, 32'h0);
    wait_rsp("rd_x7_hold", 5);
    chk("post_hold_idle", {rsp_valid, cmd_ready}, 64'b01);
    acc_cyc = cyc;
    clear_mon();
    exp_q.push_back({1'b0, 8'd36, 32'hDEAD_BEEF});
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp("rd_after_hold", 0);

    // Reset in the middle of a write aborts it with no response.
    clear_mon();
    send_cmd(1'b1, 6'd7, 32'hCAFE_F00D);
    for (int i = 0; i < 20; i++) if (cyc < acc_cyc + 10) @(negedge clk);
    chk("pre_reset_wen", 64'(wen0), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_strobes", {wen0, wreq, rsp_valid, rreq}, 64'd0);
    chk("abort_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    rsp_seen = 0;
    repeat (40) @(negedge clk);
    chk("abort_no_rsp", 64'(rsp_seen), 64'd0);
    chk("abort_queue_empty", 64'(exp_q.size()), 64'd0);
    do_txn("rd_x5_after_abort", 1'b0, 6'd5, 32'h0, 32'hDEAD_BEEF, 1'b0, 36);

    chk("reg_index_outputs", 64'(idx_bad), 64'd0);
    chk("port1_write_quiet", 64'(side_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case a wait above is broken by a stuck design.
  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
